riscv_run_controller: RTL and testbench



---
 rtl/riscv_run_controller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_riscv_run_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_controller.sv
// ============================================================================
// riscv_run_controller
// ----------------------------------------------------------------------------
// Run controller wrapped around a RISC-V core under test. It sequences the
// core's reset after a start request, supervises execution by snooping the
// fetch stream, and ends the run on a halt instruction, a stuck PC or a cycle
// timeout. It reports a status code plus RUN-cycle and retired-instruction
// counts. All outputs are registered.
//
// Optional feature (compile-time macro RUN_SIGNATURE_EN):
//   When defined, a 32-bit rolling signature of retired (pc, instr) pairs is
//   exported on the extra output port 'signature'. When undefined, neither
//   the port nor its logic exist.
//
// Ports:
//   clk           in   1     system clock, rising edge
//   reset         in   1     synchronous active-low reset
//   start         in   1     begin/restart a run (acted on in IDLE/DONE only)
//   pc            in   XLEN  core fetch PC
//   instr         in   32    core fetched instruction
//   instr_valid   in   1     pc/instr valid this cycle
//   core_reset    out  1     active-high reset to the core
//   run           out  1     high while in RUN
//   done          out  1     high while in DONE
//   status        out  2     00 none, 01 halt, 10 timeout, 11 PC stall
//   cycle_count   out  32    RUN cycles elapsed (saturating)
//   retired_count out  32    valid non-halt instructions in RUN (saturating)
//   signature     out  32    rolling signature (RUN_SIGNATURE_EN only)
// ============================================================================
module riscv_run_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 100,
  parameter int unsigned STALL_LIMIT = 4,
  parameter logic [31:0] HALT_INSN   = 32'h0000_0073
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            core_reset,
  output logic            run,
  output logic            done,
  output logic [1:0]      status,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retired_count
`ifdef RUN_SIGNATURE_EN
  ,
  output logic [31:0]     signature
`endif
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Status codes
  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_STALL   = 2'b11;

  // Terminal values of the internal counters, pre-sized to 32 bits
  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] CYC_LAST   = 32'(MAX_CYCLES - 1);
  localparam logic [31:0] STALL_LIM  = 32'(STALL_LIMIT);

  // Saturating 32-bit increment: counters stick at all-ones, never wrap
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

  // Registered state
  logic [1:0]      r_state;
  logic [31:0]     r_rst_cnt;
  logic [31:0]     r_stall_cnt;
  logic [XLEN-1:0] r_prev_pc;
  logic            r_prev_pc_valid;
  logic [31:0]     r_cycle_count;
  logic [31:0]     r_retired_count;
  logic [1:0]      r_status;
  logic            r_core_reset;
  logic            r_run;
  logic            r_done;

  // Next-state values
  logic [1:0]      w_state_nxt;
  logic [31:0]     w_rst_cnt_nxt;
  logic [31:0]     w_stall_cnt_nxt;
  logic [XLEN-1:0] w_prev_pc_nxt;
  logic            w_prev_pc_valid_nxt;
  logic [31:0]     w_cycle_count_nxt;
  logic [31:0]     w_retired_count_nxt;
  logic [1:0]      w_status_nxt;

  // Fetch-stream decode
  logic            w_is_halt;
  logic            w_retire;
  logic            w_pc_same;
  logic [31:0]     w_stall_upd;

  assign w_is_halt   = instr_valid && (instr == HALT_INSN);
  assign w_retire    = instr_valid && (instr != HALT_INSN);
  assign w_pc_same   = r_prev_pc_valid && (pc == r_prev_pc);
  // Repeated PC extends the streak; a new PC (or no previous PC) restarts it
  assign w_stall_upd = w_pc_same ? (r_stall_cnt + 32'd1) : 32'd0;

`ifdef RUN_SIGNATURE_EN
  logic [31:0] r_signature;
  logic [31:0] w_signature_nxt;
  logic [31:0] w_pc32;

  // Narrow PCs are zero-extended into the 32-bit signature
  if (XLEN >= 32) begin : g_pc_wide
    assign w_pc32 = pc[31:0];
  end else begin : g_pc_narrow
    assign w_pc32 = {{(32 - XLEN){1'b0}}, pc};
  end
`endif

  // Next-state and next-output computation for the run FSM
  always_comb begin
    w_state_nxt         = r_state;
    w_rst_cnt_nxt       = r_rst_cnt;
    w_stall_cnt_nxt     = r_stall_cnt;
    w_prev_pc_nxt       = r_prev_pc;
    w_prev_pc_valid_nxt = r_prev_pc_valid;
    w_cycle_count_nxt   = r_cycle_count;
    w_retired_count_nxt = r_retired_count;
    w_status_nxt        = r_status;
`ifdef RUN_SIGNATURE_EN
    w_signature_nxt     = r_signature;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        // Start (or restart) clears all results before the reset phase
        if (start) begin
          w_state_nxt         = S_RST;
          w_rst_cnt_nxt       = 32'd0;
          w_stall_cnt_nxt     = 32'd0;
          w_prev_pc_valid_nxt = 1'b0;
          w_cycle_count_nxt   = 32'd0;
          w_retired_count_nxt = 32'd0;
          w_status_nxt        = ST_NONE;
`ifdef RUN_SIGNATURE_EN
          w_signature_nxt     = 32'd0;
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end

      S_RST: begin
        // r_rst_cnt counts cycles spent in RST, starting at 0 on entry
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt         = S_RUN;
          w_prev_pc_valid_nxt = 1'b0;
          w_stall_cnt_nxt     = 32'd0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 32'd1;
        end
      end

      S_RUN: begin
        // The terminating cycle is counted as a RUN cycle too
        w_cycle_count_nxt = sat_inc(r_cycle_count);

        if (w_retire) begin
          w_retired_count_nxt = sat_inc(r_retired_count);
          w_stall_cnt_nxt     = w_stall_upd;
          w_prev_pc_nxt       = pc;
          w_prev_pc_valid_nxt = 1'b1;
`ifdef RUN_SIGNATURE_EN
          w_signature_nxt     = {r_signature[30:0], r_signature[31]} ^ w_pc32 ^ instr;
`endif
        end else begin
          w_stall_cnt_nxt = r_stall_cnt;
        end

        // Priority: halt > stall > timeout
        if (w_is_halt) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_HALT;
        end else if (w_retire && (w_stall_upd == STALL_LIM)) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_STALL;
        end else if (r_cycle_count == CYC_LAST) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_rst_cnt       <= 32'd0;
      r_stall_cnt     <= 32'd0;
      r_prev_pc       <= '0;
      r_prev_pc_valid <= 1'b0;
      r_cycle_count   <= 32'd0;
      r_retired_count <= 32'd0;
      r_status        <= ST_NONE;
      r_core_reset    <= 1'b1;
      r_run           <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_rst_cnt       <= w_rst_cnt_nxt;
      r_stall_cnt     <= w_stall_cnt_nxt;
      r_prev_pc       <= w_prev_pc_nxt;
      r_prev_pc_valid <= w_prev_pc_valid_nxt;
      r_cycle_count   <= w_cycle_count_nxt;
      r_retired_count <= w_retired_count_nxt;
      r_status        <= w_status_nxt;
      // Core is held in reset only in IDLE/RST; DONE leaves it out of reset
      // so its state can be inspected
      r_core_reset    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RST);
      r_run           <= (w_state_nxt == S_RUN);
      r_done          <= (w_state_nxt == S_DONE);
    end
  end

`ifdef RUN_SIGNATURE_EN
  // Signature register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_signature <= 32'd0;
    end else begin
      r_signature <= w_signature_nxt;
    end
  end

  assign signature = r_signature;
`endif

  assign core_reset    = r_core_reset;
  assign run           = r_run;
  assign done          = r_done;
  assign status        = r_status;
  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_riscv_run_controller.sv
module tb_riscv_run_controller;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        core_reset;
  logic        run;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
`ifdef RUN_SIGNATURE_EN
  logic [31:0] signature;
  logic [31:0] exp_sig;
`endif

  int n_checks;
  int n_errors;

  riscv_run_controller #(
    .XLEN(32), .RST_CYCLES(2), .MAX_CYCLES(100), .STALL_LIMIT(4), .HALT_INSN(32'h0000_0073)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .core_reset(core_reset), .run(run), .done(done),
    .status(status), .cycle_count(cycle_count), .retired_count(retired_count)
`ifdef RUN_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse then wait through the 2 RST cycles (no checks)
  task automatic go_to_run();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; instr_valid = 1'b0; pc = 32'd0; instr = NOP;
    tick(); tick();
    n_checks++;
    if ({core_reset, run, done, status} !== 5'b10000) begin
      $display("FAIL reset_ctrl: got cr/run/done/st=%b expected 10000", {core_reset, run, done, status});
      n_errors++;
    end
    n_checks++;
    if ({cycle_count, retired_count} !== 64'd0) begin
      $display("FAIL reset_counts: got cyc=%0d ret=%0d expected 0 0", cycle_count, retired_count);
      n_errors++;
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_start_seq();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({core_reset, run} !== 2'b10) begin
      $display("FAIL rst_cycle1: got cr/run=%b expected 10", {core_reset, run});
      n_errors++;
    end
    tick();
    n_checks++;
    if ({core_reset, run} !== 2'b10) begin
      $display("FAIL rst_cycle2: got cr/run=%b expected 10", {core_reset, run});
      n_errors++;
    end
    tick();
    n_checks++;
    if ({core_reset, run, done} !== 3'b010) begin
      $display("FAIL run_entry: got cr/run/done=%b expected 010", {core_reset, run, done});
      n_errors++;
    end
  endtask

  // continues from RUN entered in test_start_seq
  task automatic test_halt();
`ifdef RUN_SIGNATURE_EN
    exp_sig = 32'd0;
`endif
    instr_valid = 1'b1; instr = NOP;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(i * 4);
`ifdef RUN_SIGNATURE_EN
      exp_sig = {exp_sig[30:0], exp_sig[31]} ^ pc ^ instr;
`endif
      tick();
    end
    // start in RUN must be ignored
    n_checks++;
    if ({run, done, retired_count} !== {2'b10, 32'd5}) begin
      $display("FAIL halt_pre: got run=%b done=%b ret=%0d expected 1 0 5", run, done, retired_count);
      n_errors++;
    end
    pc = 32'd20; instr = HALT; start = 1'b1;
    tick();
    start = 1'b0; instr_valid = 1'b0;
    n_checks++;
    if ({core_reset, run, done, status} !== 5'b00101) begin
      $display("FAIL halt_ctrl: got cr/run/done/st=%b expected 00101", {core_reset, run, done, status});
      n_errors++;
    end
    n_checks++;
    if ({cycle_count, retired_count} !== {32'd6, 32'd5}) begin
      $display("FAIL halt_counts: got cyc=%0d ret=%0d expected 6 5", cycle_count, retired_count);
      n_errors++;
    end
`ifdef RUN_SIGNATURE_EN
    n_checks++;
    if (signature !== exp_sig) begin
      $display("FAIL halt_sig: got %h expected %h", signature, exp_sig);
      n_errors++;
    end
`endif
    // DONE freezes results even with valid traffic
    instr_valid = 1'b1; instr = NOP; pc = 32'd24;
    tick(); tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({done, status, cycle_count, retired_count} !== {1'b1, 2'b01, 32'd6, 32'd5}) begin
      $display("FAIL done_frozen: got done=%b st=%b cyc=%0d ret=%0d expected 1 01 6 5", done, status, cycle_count, retired_count);
      n_errors++;
    end
  endtask

  task automatic test_restart();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({core_reset, run, done, status, cycle_count, retired_count} !== {5'b10000, 64'd0}) begin
      $display("FAIL restart: got cr/run/done/st=%b cyc=%0d ret=%0d expected 10000 0 0", {core_reset, run, done, status}, cycle_count, retired_count);
      n_errors++;
    end
    tick(); tick();
    n_checks++;
    if ({core_reset, run} !== 2'b01) begin
      $display("FAIL restart_run: got cr/run=%b expected 01", {core_reset, run});
      n_errors++;
    end
  endtask

  // continues from RUN entered in test_restart; one idle gap must not break the streak
  task automatic test_stall();
    pc = 32'h40; instr = NOP;
    instr_valid = 1'b1; tick(); tick();
    instr_valid = 1'b0; tick();
    instr_valid = 1'b1; tick(); tick();
    n_checks++;
    if ({done, run} !== 2'b01) begin
      $display("FAIL stall_early: got done/run=%b expected 01", {done, run});
      n_errors++;
    end
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({done, status, cycle_count, retired_count} !== {1'b1, 2'b11, 32'd6, 32'd5}) begin
      $display("FAIL stall: got done=%b st=%b cyc=%0d ret=%0d expected 1 11 6 5", done, status, cycle_count, retired_count);
      n_errors++;
    end
  endtask

  task automatic test_timeout(input logic halt_last);
    logic [1:0]  exp_st;
    logic [31:0] exp_ret;
    exp_st  = halt_last ? 2'b01 : 2'b10;
    exp_ret = halt_last ? 32'd99 : 32'd100;
    go_to_run();
    instr_valid = 1'b1; instr = NOP;
    for (int i = 0; i < 99; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    n_checks++;
    if ({done, cycle_count} !== {1'b0, 32'd99}) begin
      $display("FAIL timeout_pre: got done=%b cyc=%0d expected 0 99", done, cycle_count);
      n_errors++;
    end
    pc = 32'd396; instr = halt_last ? HALT : NOP;
    tick();
    instr_valid = 1'b0;
    n_checks++;
    if ({done, status, cycle_count, retired_count} !== {1'b1, exp_st, 32'd100, exp_ret}) begin
      $display("FAIL timeout(halt=%0d): got done=%b st=%b cyc=%0d ret=%0d expected 1 %b 100 %0d", halt_last, done, status, cycle_count, retired_count, exp_st, exp_ret);
      n_errors++;
    end
  endtask

  task automatic test_reset_mid_run();
    go_to_run();
    instr_valid = 1'b1; instr = NOP;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1; instr_valid = 1'b0;
    n_checks++;
    if ({core_reset, run, done, status, cycle_count, retired_count} !== {5'b10000, 64'd0}) begin
      $display("FAIL reset_mid_run: got cr/run/done/st=%b cyc=%0d ret=%0d expected 10000 0 0", {core_reset, run, done, status}, cycle_count, retired_count);
      n_errors++;
    end
    tick(); tick();
    n_checks++;
    if ({core_reset, run, done} !== 3'b100) begin
      $display("FAIL idle_hold: got cr/run/done=%b expected 100", {core_reset, run, done});
      n_errors++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_start_seq();
    test_halt();
    test_restart();
    test_stall();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
